// File: rtl/ddr_read_arbiter.sv
// ddr_read_arbiter: round-robin sharing of one DDR read master between NUM_REQ requesters
module ddr_read_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDRESS_WIDTH = 31,
  parameter int WORD_BYTES = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req_go,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_read_base,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_read_length,
  input  logic [NUM_REQ-1:0]               req_release,
  input  logic [NUM_REQ-1:0]               req_read_buffer,
  output logic [NUM_REQ-1:0]               req_data_available,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [255:0]                     req_buffer_data,
  output logic [NUM_REQ-1:0]               req_overflow,
  output logic                             control_fixed_location,
  output logic [ADDRESS_WIDTH-1:0]         control_read_base,
  output logic [ADDRESS_WIDTH-1:0]         control_read_length,
  output logic                             control_go,
  input  logic                             control_done,
  output logic                             user_read_buffer,
  input  logic                             user_data_available,
  input  logic [255:0]                     user_buffer_data
);
  localparam int AW = ADDRESS_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int WS = $clog2(WORD_BYTES);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, WAIT_DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] cap_base [NUM_REQ];
  logic [AW-1:0] cap_len [NUM_REQ];
  logic [NUM_REQ-1:0] pending, busy, accept, drop;
  logic [IW-1:0] owner, rr_ptr, sel, cand, sel_inc, owner_inc;
  logic found, grant, skip, pop, done_low_seen;
  logic [AW-1:0] popped, popped_n, expected, sel_len, sel_expected;
  assign control_fixed_location = 1'b0;
  assign req_buffer_data = user_buffer_data;
  assign user_read_buffer = pop;
  // per-requester view: a go is queued unless one is pending or the requester still owns the master
  always_comb begin
    busy = '0;
    req_done = '0;
    req_data_available = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      busy[i] = state != IDLE && owner == IW'(i) && !(state == ACTIVE && req_release[i]);
      req_done[i] = !pending[i] && !(state != IDLE && owner == IW'(i));
      req_data_available[i] = state == ACTIVE && owner == IW'(i) && user_data_available;
    end
    accept = req_go & ~pending & ~busy;
    drop = req_go & (pending | busy);
  end
  // round-robin pick of the first pending requester at or after rr_ptr
  always_comb begin
    found = 1'b0;
    sel = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % NUM_REQ);
      if (pending[cand]) begin
        found = 1'b1;
        sel = cand;
      end
    end
    sel_len = cap_len[sel];
    sel_expected = (sel_len >> WS) + AW'(|sel_len[WS-1:0]);
    sel_inc = (sel == IW'(NUM_REQ - 1)) ? '0 : sel + IW'(1);
    owner_inc = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    grant = state == IDLE && found && sel_len != '0;
    skip = state == IDLE && found && sel_len == '0;
  end
  // pop routing (owner in ACTIVE, arbiter itself in DRAIN) and next-state selection
  always_comb begin
    pop = state == ACTIVE ? req_read_buffer[owner] & user_data_available :
          state == DRAIN  ? user_data_available & (popped != expected) : 1'b0;
    popped_n = popped + AW'(pop);
    state_n = state == IDLE   ? (grant ? ACTIVE : IDLE) :
              state == ACTIVE ? (popped_n == expected ? WAIT_DONE : req_release[owner] ? DRAIN : ACTIVE) :
              state == DRAIN  ? (popped_n == expected ? WAIT_DONE : DRAIN) :
              (control_done && done_low_seen ? IDLE : WAIT_DONE);
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // request queueing, transaction launch, word counting and round-robin pointer
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      req_overflow <= '0;
      rr_ptr <= '0;
      owner <= '0;
      popped <= '0;
      expected <= '0;
      done_low_seen <= 1'b0;
      control_go <= 1'b0;
      control_read_base <= '0;
      control_read_length <= '0;
    end else begin
      pending <= (pending & ~((grant | skip) ? NUM_REQ'(1) << sel : '0)) | accept;
      req_overflow <= req_overflow | drop;
      control_go <= grant;
      popped <= grant ? '0 : popped_n;
      done_low_seen <= !grant && (done_low_seen || !control_done || popped_n == expected);
      if (grant) begin
        owner <= sel;
        expected <= sel_expected;
        control_read_base <= cap_base[sel];
        control_read_length <= sel_len;
      end
      if (skip) rr_ptr <= sel_inc;
      else if (state == WAIT_DONE && state_n == IDLE) rr_ptr <= owner_inc;
    end
  // captured go parameters; only read while the pending bit is set, so no reset is needed
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_REQ; i++)
      if (accept[i]) begin
        cap_base[i] <= req_read_base[i*AW +: AW];
        cap_len[i] <= req_read_length[i*AW +: AW];
      end
endmodule
